// File: rtl/touch_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : touch_pio_pkg
//  Purpose  : Shared register map, edge-type codes and edge-event helper for
//             the touch_bidir_pio bidirectional PIO.
//  Revision : 1.0 - initial release
// ============================================================================
package touch_pio_pkg;

  // Avalon register indices
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  // Edge capture selection
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Single-bit edge event for the selected edge type
  function automatic logic edge_event(input logic prev, input logic cur,
                                      input int edge_type);
    logic ev;
    case (edge_type)
      EDGE_RISE: ev = ~prev & cur;
      EDGE_FALL: ev = prev & ~cur;
      default:   ev = prev ^ cur;
    endcase
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pio_input_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pio_input_sync
//  Purpose  : Pin synchroniser chain, previous-value flop and per-bit edge
//             event vector for the bidirectional PIO.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_input_sync
  import touch_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] event_o
);

  // The chain restarts from zero on reset while the pins usually sit high,
  // so events stay disarmed until both the last stage and the previous-value
  // flop hold real pin samples (covers the first cycle after reset as well).
  localparam logic [2:0] c_WARM_LEN = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_q;
  logic             w_armed;

  // Synchroniser shift, previous-value capture and post-reset warm-up count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
      warm_q <= c_WARM_LEN;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (warm_q != 3'd0) warm_q <= warm_q - 3'd1;
    end
  end

  assign sync_o  = sync_q[SYNC_STAGES-1];
  assign w_armed = (warm_q == 3'd0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_evt
    assign event_o[i] = w_armed & edge_event(prev_q[i], sync_o[i], EDGE_TYPE);
  end

endmodule
`default_nettype wire

// File: rtl/touch_bidir_pio.sv
`default_nettype none
// ============================================================================
//  Module   : touch_bidir_pio
//  Purpose  : N-bit bidirectional PIO on an Avalon-MM slave with per-bit
//             direction, atomic set/clear, edge capture with masked IRQ and
//             optional open-drain pin drive.
//  Revision : 1.0 - initial release
// ============================================================================
module touch_bidir_pio
  import touch_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter bit               OPEN_DRAIN  = 1'b1,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter logic [WIDTH-1:0] OUT_RESET   = '1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  pio_input_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (bidir_port),
    .sync_o  (w_sync),
    .event_o (w_event)
  );

  assign w_wr = chipselect & ~write_n;

  // Register writes, sticky edge capture with W1C, and read mux
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    w_clr      = '0;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   data_out_d = writedata;
        ADDR_DIR:    dir_d      = writedata;
        ADDR_MASK:   mask_d     = writedata;
        ADDR_EDGE:   w_clr      = writedata;
        ADDR_OUTSET: data_out_d = data_out_q | writedata;
        ADDR_OUTCLR: data_out_d = data_out_q & ~writedata;
        default:     ;
      endcase
    end
    // A fresh event wins over a simultaneous clear so no edge is lost
    edge_cap_d = w_event | (edge_cap_q & ~w_clr);
    case (address)
      ADDR_DATA:   readdata_d = w_sync;
      ADDR_DIR:    readdata_d = dir_q;
      ADDR_MASK:   readdata_d = mask_q;
      ADDR_EDGE:   readdata_d = edge_cap_q;
      ADDR_OUTSET: readdata_d = data_out_q;
      ADDR_OUTCLR: readdata_d = data_out_q;
      default:     readdata_d = '0;
    endcase
  end

  // Register state update
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= OUT_RESET;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & mask_q);

  // Pin drivers: open-drain only ever pulls low, push-pull drives both levels
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    if (OPEN_DRAIN) begin : g_od
      assign bidir_port[i] = (dir_q[i] & ~data_out_q[i]) ? 1'b0 : 1'bz;
    end else begin : g_pp
      assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_touch_bidir_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_touch_bidir_pio
//  Purpose  : Self-checking bench for touch_bidir_pio: an open-drain rising-
//             edge instance and a push-pull any-edge instance share one bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_touch_bidir_pio;

  localparam int SA = 2;  // sync stages, open-drain instance
  localparam int SB = 3;  // sync stages, push-pull instance

  logic       clk = 1'b0;
  logic       reset, chipselect, write_n;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] rd_a, rd_b;
  logic       irq_a, irq_b;
  wire  [7:0] pins_a, pins_b;
  logic [7:0] ext_oe, ext_val;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state
  logic [7:0] m_out, m_dir, m_mask, m_cap_a, m_cap_b;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pins_a[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    assign pins_b[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    pullup pu_a (pins_a[i]);
    pullup pu_b (pins_b[i]);
  end

  touch_bidir_pio #(.WIDTH(8), .OPEN_DRAIN(1'b1), .DIR_RESET(8'h00),
                    .OUT_RESET(8'hFF), .SYNC_STAGES(SA), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a),
    .bidir_port(pins_a));

  touch_bidir_pio #(.WIDTH(8), .OPEN_DRAIN(1'b0), .DIR_RESET(8'h00),
                    .OUT_RESET(8'hFF), .SYNC_STAGES(SB), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .irq(irq_b),
    .bidir_port(pins_b));

  // Resolved pin level with pull-ups and the external driver
  function automatic logic [7:0] exp_pins(input bit od, input logic [7:0] dir,
                                          input logic [7:0] out, input logic [7:0] oe,
                                          input logic [7:0] val);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      if (od) p[i] = (dir[i] && !out[i]) ? 1'b0 : (oe[i] ? val[i] : 1'b1);
      else    p[i] = dir[i] ? out[i] : (oe[i] ? val[i] : 1'b1);
    end
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    case (a)
      3'd0: m_out = d;
      3'd1: m_dir = d;
      3'd2: m_mask = d;
      3'd3: begin m_cap_a &= ~d; m_cap_b &= ~d; end
      3'd4: m_out |= d;
      3'd5: m_out &= ~d;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] va, output logic [7:0] vb);
    address = a;
    @(posedge clk); #1;
    va = rd_a; vb = rd_b;
  endtask

  task automatic model_reset();
    m_out = 8'hFF; m_dir = 8'h00; m_mask = 8'h00; m_cap_a = 8'h00; m_cap_b = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] a, b;
    reset = 1'b1; address = 3'd4;
    tick(3);
    checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL rst_readdata: got %h exp 00", rd_a); end
    reset = 1'b0;
    model_reset();
    tick(6);
    checks++; if (pins_a !== 8'hFF || pins_b !== 8'hFF) begin errors++; $display("FAIL rst_pins: got %h/%h exp FF", pins_a, pins_b); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b/%b exp 0", irq_a, irq_b); end
    rd(3'd1, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL rst_dir: got %h/%h exp 00", a, b); end
    rd(3'd0, a, b);
    checks++; if (a !== 8'hFF || b !== 8'hFF) begin errors++; $display("FAIL rst_data: got %h/%h exp FF", a, b); end
    rd(3'd3, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL rst_edge: got %h/%h exp 00", a, b); end
    rd(3'd4, a, b);
    checks++; if (a !== 8'hFF || b !== 8'hFF) begin errors++; $display("FAIL rst_dout: got %h/%h exp FF", a, b); end
  endtask

  task automatic test_drive();
    logic [7:0] a, b;
    wr(3'd1, 8'h0F);
    wr(3'd0, 8'h05);
    tick(5);
    checks++; if (pins_a !== 8'hF5) begin errors++; $display("FAIL drive_od_pins: got %h exp F5", pins_a); end
    checks++; if (pins_b !== 8'hF5) begin errors++; $display("FAIL drive_pp_pins: got %h exp F5", pins_b); end
    rd(3'd4, a, b);
    checks++; if (a !== 8'h05 || b !== 8'h05) begin errors++; $display("FAIL drive_outset_rd: got %h/%h exp 05", a, b); end
    rd(3'd0, a, b);
    checks++; if (a !== 8'hF5 || b !== 8'hF5) begin errors++; $display("FAIL drive_data_rd: got %h/%h exp F5", a, b); end
  endtask

  task automatic test_set_clr();
    logic [7:0] a, b, d, pa, pb;
    logic [2:0] ad;
    wr(3'd4, 8'h30);
    wr(3'd5, 8'h01);
    rd(3'd5, a, b);
    checks++; if (a !== 8'h34 || b !== 8'h34) begin errors++; $display("FAIL setclr_fixed: got %h/%h exp 34", a, b); end
    wr(3'd6, 8'hAA);
    wr(3'd7, 8'h55);
    rd(3'd6, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL addr6_rd: got %h/%h exp 00", a, b); end
    rd(3'd4, a, b);
    checks++; if (a !== 8'h34 || b !== 8'h34) begin errors++; $display("FAIL addr67_wr_ignored: got %h/%h exp 34", a, b); end
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: ad = 3'd0;
        1: ad = 3'd1;
        2: ad = 3'd4;
        default: ad = 3'd5;
      endcase
      d = 8'($urandom);
      wr(ad, d);
      tick(4);
      rd(3'd5, a, b);
      checks++; if (a !== m_out || b !== m_out) begin errors++; $display("FAIL rand_dout[%0d]: got %h/%h exp %h", k, a, b, m_out); end
      pa = exp_pins(1'b1, m_dir, m_out, ext_oe, ext_val);
      pb = exp_pins(1'b0, m_dir, m_out, ext_oe, ext_val);
      checks++; if (pins_a !== pa || pins_b !== pb) begin errors++; $display("FAIL rand_pins[%0d]: got %h/%h exp %h/%h", k, pins_a, pins_b, pa, pb); end
      rd(3'd0, a, b);
      checks++; if (a !== pa || b !== pb) begin errors++; $display("FAIL rand_data_rd[%0d]: got %h/%h exp %h/%h", k, a, b, pa, pb); end
    end
  endtask

  task automatic test_ext_pins();
    logic [7:0] a, b, pa, pb;
    for (int k = 0; k < 10; k++) begin
      wr(3'd1, 8'($urandom));
      ext_oe  = ~m_dir & 8'($urandom);
      ext_val = 8'($urandom);
      tick(5);
      pa = exp_pins(1'b1, m_dir, m_out, ext_oe, ext_val);
      pb = exp_pins(1'b0, m_dir, m_out, ext_oe, ext_val);
      rd(3'd0, a, b);
      checks++; if (a !== pa || b !== pb) begin errors++; $display("FAIL ext_data_rd[%0d]: got %h/%h exp %h/%h", k, a, b, pa, pb); end
    end
  endtask

  task automatic test_edge_rand();
    logic [7:0] a, b, prev, cur;
    ext_oe = 8'h00;
    wr(3'd1, 8'h00);
    tick(6);
    wr(3'd3, 8'hFF);
    prev = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 1) wr(3'd3, 8'($urandom));
      if (k % 4 == 0) wr(3'd2, 8'($urandom));
      ext_oe  = 8'($urandom);
      ext_val = 8'($urandom);
      tick(7);
      cur = exp_pins(1'b1, 8'h00, m_out, ext_oe, ext_val);
      m_cap_a |= ~prev & cur;
      m_cap_b |= prev ^ cur;
      prev = cur;
      rd(3'd3, a, b);
      checks++; if (a !== m_cap_a || b !== m_cap_b) begin errors++; $display("FAIL edge_rand[%0d]: got %h/%h exp %h/%h", k, a, b, m_cap_a, m_cap_b); end
      checks++; if (irq_a !== |(m_cap_a & m_mask) || irq_b !== |(m_cap_b & m_mask)) begin
        errors++; $display("FAIL irq_rand[%0d]: got %b/%b exp %b/%b", k, irq_a, irq_b, |(m_cap_a & m_mask), |(m_cap_b & m_mask)); end
    end
  endtask

  task automatic test_edge_latency();
    logic [7:0] a, b;
    ext_oe = 8'h80; ext_val = 8'h00;
    tick(7);
    wr(3'd3, 8'hFF);
    wr(3'd2, 8'h80);
    ext_val = 8'h80;
    tick(SA);
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL lat_early: got %b/%b exp 0/0", irq_a, irq_b); end
    tick(1);
    checks++; if (irq_a !== 1'b1 || irq_b !== 1'b0) begin errors++; $display("FAIL lat_a: got %b/%b exp 1/0", irq_a, irq_b); end
    tick(SB - SA);
    checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL lat_b: got %b exp 1", irq_b); end
    rd(3'd3, a, b);
    checks++; if (a !== 8'h80 || b !== 8'h80) begin errors++; $display("FAIL rise_cap: got %h/%h exp 80/80", a, b); end
    wr(3'd3, 8'h80);
    ext_val = 8'h00;
    tick(7);
    rd(3'd3, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h80) begin errors++; $display("FAIL fall_cap: got %h/%h exp 00/80", a, b); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b1) begin errors++; $display("FAIL fall_irq: got %b/%b exp 0/1", irq_a, irq_b); end
  endtask

  task automatic test_w1c_collision();
    logic [7:0] a, b;
    ext_val = 8'h80;
    tick(SA);
    wr(3'd3, 8'h80);
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b exp 1", irq_a); end
    tick(2);
    rd(3'd3, a, b);
    checks++; if (a !== 8'h80 || b !== 8'h80) begin errors++; $display("FAIL collide_cap: got %h/%h exp 80/80", a, b); end
    wr(3'd3, 8'h80);
    rd(3'd3, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL collide_clear: got %h/%h exp 00/00", a, b); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL collide_irq_clr: got %b/%b exp 0/0", irq_a, irq_b); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b;
    ext_oe = 8'h00;
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'h00);
    tick(6);
    checks++; if (pins_a !== 8'h00 || pins_b !== 8'h00) begin errors++; $display("FAIL pre_rst_pins: got %h/%h exp 00", pins_a, pins_b); end
    wr(3'd3, 8'hFF);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 8'hFF;
    reset = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    model_reset();
    checks++; if (pins_a !== 8'hFF || pins_b !== 8'hFF) begin errors++; $display("FAIL rst_mid_pins: got %h/%h exp FF", pins_a, pins_b); end
    reset = 1'b0;
    tick(10);
    rd(3'd3, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL rst_mid_edge: got %h/%h exp 00", a, b); end
    rd(3'd1, a, b);
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL rst_mid_dir: got %h/%h exp 00", a, b); end
    rd(3'd4, a, b);
    checks++; if (a !== 8'hFF || b !== 8'hFF) begin errors++; $display("FAIL rst_mid_dout: got %h/%h exp FF", a, b); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: got %b/%b exp 0", irq_a, irq_b); end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = 8'h00; ext_oe = 8'h00; ext_val = 8'h00;
    model_reset();
    test_reset();
    test_drive();
    test_set_clr();
    test_ext_pins();
    test_edge_rand();
    test_edge_latency();
    test_w1c_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
